// File: rtl/control_sequencer.sv
// Timing-and-control sequencer for the 16-bit accumulator processor.
// Steps T0..T6 through fetch, decode and execute; outputs decode the step.
module control_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        dr_zero,
    output logic [2:0]  bus_sel,
    output logic        ld_ar,
    output logic        ld_pc,
    output logic        ld_dr,
    output logic        ld_ac,
    output logic        ld_ir,
    output logic        inc_ar,
    output logic        inc_pc,
    output logic        inc_dr,
    output logic        inc_ac,
    output logic        clr_ac,
    output logic [1:0]  alu_op,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halted,
    output logic [2:0]  sc
);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_MEM  = 3'd6;

    logic [2:0] sc_q, sc_d;
    logic       halted_q, halted_d;
    logic       i_flag_q, i_flag_d;
    logic [2:0] op;
    logic       unused_ir;

    assign op        = ir[14:12];
    assign unused_ir = ^{ir[10], ir[8:6], ir[4:1]};
    assign sc        = sc_q;
    assign halted    = halted_q;
    assign mem_rd    = (bus_sel == SEL_MEM);

    // Sequence counter, halt and indirect flags; reset leaves the core halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q     <= 3'd0;
            halted_q <= 1'b1;
            i_flag_q <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            halted_q <= halted_d;
            i_flag_q <= i_flag_d;
        end
    end

    // Step decode: control strobes for this step and the next sequence state.
    always_comb begin
        sc_d     = sc_q + 3'd1;
        halted_d = halted_q;
        i_flag_d = i_flag_q;
        bus_sel  = SEL_NONE;
        ld_ar    = 1'b0;
        ld_pc    = 1'b0;
        ld_dr    = 1'b0;
        ld_ac    = 1'b0;
        ld_ir    = 1'b0;
        inc_ar   = 1'b0;
        inc_pc   = 1'b0;
        inc_dr   = 1'b0;
        inc_ac   = 1'b0;
        clr_ac   = 1'b0;
        alu_op   = 2'd0;
        mem_wr   = 1'b0;
        if (halted_q) begin
            sc_d = 3'd0;
            if (start) halted_d = 1'b0;
        end else begin
            unique case (sc_q)
                3'd0: begin
                    bus_sel = SEL_PC;
                    ld_ar   = 1'b1;
                end
                3'd1: begin
                    bus_sel = SEL_MEM;
                    ld_ir   = 1'b1;
                    inc_pc  = 1'b1;
                end
                3'd2: begin
                    bus_sel  = SEL_IR;
                    ld_ar    = 1'b1;
                    i_flag_d = ir[15];
                end
                3'd3: begin
                    if (op != 3'd7) begin
                        if (i_flag_q) begin
                            bus_sel = SEL_MEM;
                            ld_ar   = 1'b1;
                        end
                    end else begin
                        sc_d = 3'd0;
                        if (!i_flag_q) begin
                            if (ir[0]) begin
                                halted_d = 1'b1;
                            end else if (ir[11]) begin
                                clr_ac = 1'b1;
                            end else if (ir[9]) begin
                                alu_op = 2'd3;
                                ld_ac  = 1'b1;
                            end else if (ir[5]) begin
                                inc_ac = 1'b1;
                            end
                        end
                    end
                end
                3'd4: begin
                    unique case (op)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            bus_sel = SEL_MEM;
                            ld_dr   = 1'b1;
                        end
                        3'd3: begin
                            bus_sel = SEL_AC;
                            mem_wr  = 1'b1;
                            sc_d    = 3'd0;
                        end
                        3'd4: begin
                            bus_sel = SEL_AR;
                            ld_pc   = 1'b1;
                            sc_d    = 3'd0;
                        end
                        3'd5: begin
                            bus_sel = SEL_PC;
                            mem_wr  = 1'b1;
                            inc_ar  = 1'b1;
                        end
                        default: sc_d = 3'd0;
                    endcase
                end
                3'd5: begin
                    unique case (op)
                        3'd0: begin
                            alu_op = 2'd1;
                            ld_ac  = 1'b1;
                            sc_d   = 3'd0;
                        end
                        3'd1: begin
                            alu_op = 2'd2;
                            ld_ac  = 1'b1;
                            sc_d   = 3'd0;
                        end
                        3'd2: begin
                            alu_op = 2'd0;
                            ld_ac  = 1'b1;
                            sc_d   = 3'd0;
                        end
                        3'd5: begin
                            bus_sel = SEL_AR;
                            ld_pc   = 1'b1;
                            sc_d    = 3'd0;
                        end
                        3'd6: inc_dr = 1'b1;
                        default: sc_d = 3'd0;
                    endcase
                end
                3'd6: begin
                    sc_d = 3'd0;
                    if (op == 3'd6) begin
                        bus_sel = SEL_DR;
                        mem_wr  = 1'b1;
                        inc_pc  = dr_zero;
                    end
                end
                default: sc_d = 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus
// random instruction streams compared against a table-driven step model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ir;
    logic        dr_zero;
    logic [2:0]  bus_sel;
    logic        ld_ar, ld_pc, ld_dr, ld_ac, ld_ir;
    logic        inc_ar, inc_pc, inc_dr, inc_ac;
    logic        clr_ac;
    logic [1:0]  alu_op;
    logic        mem_rd, mem_wr;
    logic        halted;
    logic [2:0]  sc;

    int tests = 0;
    int fails = 0;

    control_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .dr_zero(dr_zero),
        .bus_sel(bus_sel), .ld_ar(ld_ar), .ld_pc(ld_pc), .ld_dr(ld_dr),
        .ld_ac(ld_ac), .ld_ir(ld_ir), .inc_ar(inc_ar), .inc_pc(inc_pc),
        .inc_dr(inc_dr), .inc_ac(inc_ac), .clr_ac(clr_ac), .alu_op(alu_op),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .sc(sc)
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {bus_sel, ld_ar, ld_pc, ld_dr, ld_ac, ld_ir,
                  inc_ar, inc_pc, inc_dr, inc_ac, clr_ac, alu_op,
                  mem_rd, mem_wr, halted, sc};

    // Idle vector seen while halted: only halted=1.
    localparam logic [20:0] IDLE = 21'h8;

    // Cycles per instruction, straight from the instruction-length table.
    function automatic int instr_len(input logic [15:0] v);
        case (v[14:12])
            3'd7:       return 4;
            3'd3, 3'd4: return 5;
            3'd6:       return 7;
            default:    return 6;
        endcase
    endfunction

    function automatic bit is_hlt(input logic [15:0] v);
        return v[14:12] == 3'd7 && !v[15] && v[0];
    endfunction

    // Expected outputs at step k of instruction v while running.
    function automatic logic [20:0] model(input int k, input logic [15:0] v,
                                          input logic dz);
        logic [2:0] sel;
        logic lar, lpc, ldr, lac, lir, iar, ipc, idr, iac, cac, wr;
        logic [1:0] alu;
        logic [1:0] alu_tab [3];
        logic [2:0] op;
        logic [2:0] k3;
        alu_tab = '{2'd1, 2'd2, 2'd0};
        op = v[14:12];
        k3 = 3'(k);
        sel = 0; alu = 0;
        {lar, lpc, ldr, lac, lir, iar, ipc, idr, iac, cac, wr} = '0;
        if (k == 0) begin sel = 2; lar = 1; end
        else if (k == 1) begin sel = 6; lir = 1; ipc = 1; end
        else if (k == 2) begin sel = 5; lar = 1; end
        else if (k == 3) begin
            if (op != 7 && v[15]) begin sel = 6; lar = 1; end
            if (op == 7 && !v[15] && !v[0]) begin
                if (v[11]) cac = 1;
                else if (v[9]) begin alu = 3; lac = 1; end
                else if (v[5]) iac = 1;
            end
        end else if (op <= 2) begin
            if (k == 4) begin sel = 6; ldr = 1; end
            else begin alu = alu_tab[op]; lac = 1; end
        end else if (op == 3) begin sel = 4; wr = 1; end
        else if (op == 4) begin sel = 1; lpc = 1; end
        else if (op == 5) begin
            if (k == 4) begin sel = 2; wr = 1; iar = 1; end
            else begin sel = 1; lpc = 1; end
        end else if (op == 6) begin
            if (k == 4) begin sel = 6; ldr = 1; end
            else if (k == 5) idr = 1;
            else begin sel = 3; wr = 1; ipc = dz; end
        end
        return {sel, lar, lpc, ldr, lac, lir, iar, ipc, idr, iac, cac, alu,
                sel == 3'd6, wr, 1'b0, k3};
    endfunction

    task automatic chk(input string tag, input logic [20:0] got,
                       input logic [20:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from T0 to its last step, checking every step.
    task automatic run_instr(input logic [15:0] v, input int dz_mode,
                             input bit rnd_start);
        int n;
        n = instr_len(v);
        for (int k = 0; k < n; k++) begin
            ir = v;
            dr_zero = (dz_mode == 2) ? 1'($urandom) : 1'(dz_mode);
            start = rnd_start ? 1'($urandom) : 1'b0;
            #1;
            chk($sformatf("ir%h_T%0d", v, k), obs, model(k, v, dr_zero));
            tick();
        end
        start = 1'b0;
    endtask

    // Pulse start from halt and confirm T0 follows.
    task automatic resume();
        start = 1'b1;
        #1;
        chk("halt_before_start", obs, IDLE);
        tick();
        start = 1'b0;
        #1;
        chk("resume_T0", obs, model(0, ir, dr_zero));
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; start = 1'b0; ir = 16'h0; dr_zero = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_idle", obs, IDLE);
        tick();
        chk("idle_hold", obs, IDLE);
        resume();

        run_instr(16'h2123, 0, 1'b0);
        run_instr(16'h9050, 0, 1'b0);
        run_instr(16'h6010, 1, 1'b0);
        run_instr(16'h6010, 0, 1'b0);
        run_instr(16'h5200, 0, 1'b0);
        run_instr(16'h7200, 0, 1'b1);
        run_instr(16'h7020, 0, 1'b0);
        run_instr(16'hF801, 0, 1'b0);
        run_instr(16'h7801, 0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("halt_idle%0d", c), obs, IDLE);
            tick();
        end
        resume();

        // Reset during T3 of STA: the T4 write must never appear.
        v = 16'h3000;
        for (int k = 0; k < 3; k++) begin
            ir = v;
            #1;
            chk($sformatf("sta_T%0d", k), obs, model(k, v, 1'b0));
            tick();
        end
        rst = 1'b1;
        #1;
        chk("sta_T3", obs, model(3, v, 1'b0));
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("sta_abort%0d", c), obs, IDLE);
            tick();
        end
        resume();

        // Random instruction stream, rare halts, random ignored start pulses.
        for (int n = 0; n < 80; n++) begin
            v = 16'($urandom);
            if (is_hlt(v) && $urandom_range(3) != 0) v[0] = 1'b0;
            run_instr(v, 2, 1'b1);
            if (is_hlt(v)) begin
                #1;
                chk("rnd_halt", obs, IDLE);
                tick();
                resume();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
